spi_write_arbiter: RTL and testbench

SPI_WRITE_ARBITER -- requirements
Module: spi_write_arbiter

---
 rtl/spi_write_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_spi_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_arbiter.sv
// spi_write_arbiter: arbitrates write requests from NREQ requesters onto one
// SPI master. Each frame is {1'b1, adr[6:0]} followed by NBIT data bits, MSB
// first, in SPI mode 0 (sclk idles low, mosi stable at every sclk rise).
//
// Optional feature: define SPI_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, arbitration is fixed priority with the lowest index winning.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   req   - per-requester write request, held until the matching ack
//   adr   - requester i address in [7i+6:7i]
//   data  - requester i data in [NBIT*i+NBIT-1:NBIT*i]
//   ack   - one-cycle completion pulse, coincident with the cs rise
//   sclk  - SPI clock, idle low
//   mosi  - serial data out
//   cs    - active-low chip select
//   busy  - high from grant until the end of the inter-frame gap
module spi_write_arbiter #(
    parameter int unsigned NBIT     = 8,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 8,
    parameter int unsigned CS_GAP   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [7*NREQ-1:0]      adr,
    input  logic [NBIT*NREQ-1:0]   data,
    output logic [NREQ-1:0]        ack,
    output logic                   sclk,
    output logic                   mosi,
    output logic                   cs,
    output logic                   busy
);

    localparam int unsigned FRAME_BITS = 8 + NBIT;
    localparam int unsigned SREG_W     = FRAME_BITS - 1;
    localparam int unsigned BIT_CYC    = 2 * CLK_DIV;
    localparam int unsigned CNT_MAX    = (CS_SETUP > BIT_CYC)
                                         ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                         : ((BIT_CYC > CS_GAP) ? BIT_CYC : CS_GAP);
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned IDX_W      = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BITS_LAST  = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [SREG_W-1:0]   sreg;      // bits still to send after the one on mosi
    logic [IDX_W-1:0]    gnt;

    logic                arb_valid;
    logic [IDX_W-1:0]    arb_idx;
    logic [6:0]          sel_adr;
    logic [NBIT-1:0]     sel_data;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    // Index where the next search starts (one past the last grant).
    logic [IDX_W-1:0]    rr_ptr;

    // Round-robin search beginning at rr_ptr, wrapping NREQ-1 -> 0.
    always_comb begin : rr_search
        int unsigned j;
        arb_valid = 1'b0;
        arb_idx   = '0;
        j         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = 32'(rr_ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!arb_valid && req[IDX_W'(j)]) begin
                arb_valid = 1'b1;
                arb_idx   = IDX_W'(j);
            end
        end
    end

    // Pointer advances only when a grant is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == IDLE && arb_valid) begin
            rr_ptr <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
    end
`else
    // Fixed priority: descending scan so the lowest requesting index wins.
    always_comb begin
        arb_valid = |req;
        arb_idx   = '0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (req[IDX_W'(i - 1)]) begin
                arb_idx = IDX_W'(i - 1);
            end
        end
    end
`endif

    // Select the winning requester's address and data slices.
    always_comb begin
        sel_adr  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_adr  = adr[7*i +: 7];
                sel_data = data[NBIT*i +: NBIT];
            end
        end
    end

    // Frame sequencer with registered SPI outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            gnt     <= '0;
            ack     <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gnt     <= arb_idx;
                        sreg    <= {sel_adr, sel_data};
                        mosi    <= 1'b1;            // write flag leads the frame
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        sclk    <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        sclk <= 1'b1;
                    end
                    if (cnt == BIT_LAST) begin
                        // Falling edge: the only point where mosi may move.
                        sclk <= 1'b0;
                        cnt  <= '0;
                        if (bit_cnt == BITS_LAST) begin
                            mosi  <= 1'b0;
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            mosi    <= sreg[SREG_W-1];
                            sreg    <= {sreg[SREG_W-2:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HALF_LAST) begin
                        cs       <= 1'b1;
                        ack[gnt] <= 1'b1;
                        cnt      <= '0;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_write_arbiter.sv
// Directed bench for spi_write_arbiter (NBIT=8, NREQ=4, CLK_DIV=4,
// CS_SETUP=8, CS_GAP=8) with a synchronised SPI slave model at address 1.
module tb_spi_write_arbiter;

    localparam int NBIT      = 8;
    localparam int NREQ      = 4;
    localparam int CS_GAP    = 8;
    localparam int CS_LOW    = 140;   // 8 + 16*8 + 4
    localparam int PULSES    = 16;
    localparam int BUDGET    = 400;

    logic                 clk  = 1'b0;
    logic                 rst  = 1'b0;
    logic [NREQ-1:0]      req  = '0;
    logic [7*NREQ-1:0]    adr  = '0;
    logic [NBIT*NREQ-1:0] data = '0;
    logic [NREQ-1:0]      ack;
    logic                 sclk;
    logic                 mosi;
    logic                 cs;
    logic                 busy;

    int tests = 0;
    int fails = 0;

    // Monitor results.
    int          m_cs_low, m_pulses, m_bad_mosi, m_early_ack, m_multi_ack;
    int          m_busy_hi, m_ack_extra, m_gap, m_busy_low;
    logic [15:0] m_rx;
    logic [3:0]  m_ack_rise;
    logic        m_sclk_rise;
    bit          m_timeout;

    always #5 clk = ~clk;

    spi_write_arbiter #(
        .NBIT(8), .NREQ(4), .CLK_DIV(4), .CS_SETUP(8), .CS_GAP(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .adr (adr),
        .data(data),
        .ack (ack),
        .sclk(sclk),
        .mosi(mosi),
        .cs  (cs),
        .busy(busy)
    );

    // Slave: all SPI lines pass a 5-stage synchroniser; stage 5 is edge history.
    logic [5:0]  s_sclk = '0;
    logic [5:0]  s_mosi = '0;
    logic [5:0]  s_cs   = '1;
    logic [15:0] s_sh   = '0;
    int          s_bits = 0;
    logic [7:0]  slave_out = '0;

    always @(posedge clk) begin
        s_sclk <= {s_sclk[4:0], sclk};
        s_mosi <= {s_mosi[4:0], mosi};
        s_cs   <= {s_cs[4:0], cs};
        if (!s_cs[4] && s_cs[5]) begin
            s_bits <= 0;
            s_sh   <= '0;
        end else if (!s_cs[4] && s_sclk[4] && !s_sclk[5]) begin
            s_sh   <= {s_sh[14:0], s_mosi[4]};
            s_bits <= s_bits + 1;
        end
        if (s_cs[4] && !s_cs[5] && s_bits == 16 && s_sh[15:8] == 8'h81) begin
            slave_out <= s_sh[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [6:0] a, input logic [7:0] d);
        adr[7*i +: 7]  = a;
        data[8*i +: 8] = d;
    endtask

    task automatic decoy_slots();
        for (int i = 0; i < NREQ; i++) set_slot(i, 7'h2B, 8'hD2);
    endtask

    // Waits for cs fall, records the frame, returns at the cs-rise sample.
    task automatic monitor_frame(input logic [3:0] drop_mask);
        int   n;
        logic p_sclk, p_mosi;
        m_cs_low = 0; m_pulses = 0; m_bad_mosi = 0; m_early_ack = 0; m_multi_ack = 0;
        m_rx = '0;
        n = 0;
        while (cs !== 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
        p_sclk = sclk;
        p_mosi = mosi;
        while (cs === 1'b0 && n < BUDGET) begin
            m_cs_low++;
            if (sclk && !p_sclk) begin
                m_pulses++;
                m_rx = {m_rx[14:0], mosi};
            end
            if (mosi !== p_mosi && !(p_sclk && !sclk) && m_pulses != 0) m_bad_mosi++;
            if (ack != '0) m_early_ack++;
            if (m_cs_low == 1 && drop_mask != '0) begin
                req  = req & ~drop_mask;
                adr  = '0;
                data = '0;
            end
            p_sclk = sclk;
            p_mosi = mosi;
            @(negedge clk);
            n++;
        end
        m_timeout   = (n >= BUDGET);
        m_ack_rise  = ack;
        m_sclk_rise = sclk;
        if ($countones(ack) > 1) m_multi_ack++;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp_word, input logic [3:0] exp_ack);
        check({tag, "_timeout"},  32'(m_timeout),   32'd0);
        check({tag, "_cs_low"},   32'(m_cs_low),    32'(CS_LOW));
        check({tag, "_pulses"},   32'(m_pulses),    32'(PULSES));
        check({tag, "_mosi"},     32'(m_rx),        32'(exp_word));
        check({tag, "_mosi_mv"},  32'(m_bad_mosi),  32'd0);
        check({tag, "_ack_low"},  32'(m_early_ack), 32'd0);
        check({tag, "_ack"},      32'(m_ack_rise),  32'(exp_ack));
        check({tag, "_sclk_end"}, 32'(m_sclk_rise), 32'd0);
        check({tag, "_one_ack"},  32'(m_multi_ack), 32'd0);
    endtask

    // From the cs-rise sample, counts samples while busy stays high.
    task automatic wait_idle();
        int n;
        n = 0; m_busy_hi = 0; m_ack_extra = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n > 0 && ack != '0) m_ack_extra++;
            m_busy_hi++;
            n++;
            @(negedge clk);
        end
        m_timeout = (n >= 100);
    endtask

    // From the cs-rise sample, counts cs-high samples until the next cs fall.
    task automatic measure_gap();
        int n;
        n = 0; m_gap = 0; m_busy_low = 0; m_ack_extra = 0;
        while (cs === 1'b1 && n < 100) begin
            if (n < CS_GAP && busy !== 1'b1) m_busy_low++;
            if (n > 0 && ack != '0) m_ack_extra++;
            m_gap++;
            n++;
            @(negedge clk);
        end
        m_timeout = (n >= 100);
    endtask

    typedef struct {
        int          idx;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] exp_word;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t       vecs[4];
    logic [3:0] exp_order[4];
    int         rises, n, bad_ack, bad_sclk;
    logic       p;

    initial begin
        vecs[0] = '{2, 7'h01, 8'hA5, 16'h81A5, 4'b0100};
        vecs[1] = '{0, 7'h7F, 8'h00, 16'hFF00, 4'b0001};
        vecs[2] = '{3, 7'h00, 8'hFF, 16'h80FF, 4'b1000};
        vecs[3] = '{1, 7'h01, 8'h3C, 16'h813C, 4'b0010};
`ifdef SPI_ARB_ROUND_ROBIN_EN
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010;
        exp_order[2] = 4'b1000; exp_order[3] = 4'b0001;
`else
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0001;
        exp_order[2] = 4'b0001; exp_order[3] = 4'b0010;
`endif

        // Asynchronous reset takes effect without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_cs",   32'(cs),   32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ack",  32'(ack),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cs",   32'(cs),   32'd1);

        // Contention with req=1011 held.
        set_slot(0, 7'h10, 8'h01);
        set_slot(1, 7'h11, 8'h02);
        set_slot(2, 7'h12, 8'h03);
        set_slot(3, 7'h13, 8'h04);
        req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            monitor_frame(4'b0000);
            check($sformatf("cont%0d_timeout", k), 32'(m_timeout), 32'd0);
            check($sformatf("cont%0d_grant", k),   32'(m_ack_rise), 32'(exp_order[k]));
            check($sformatf("cont%0d_one_ack", k), 32'(m_multi_ack + m_early_ack), 32'd0);
`ifndef SPI_ARB_ROUND_ROBIN_EN
            if (k == 2) req[0] = 1'b0;
`endif
            if (k < 3) begin
                measure_gap();
                check($sformatf("gap%0d_min", k),  32'(m_gap >= CS_GAP), 32'd1);
                check($sformatf("gap%0d_busy", k), 32'(m_busy_low), 32'd0);
                check($sformatf("gap%0d_ack", k),  32'(m_ack_extra), 32'd0);
            end
        end
        req = '0;
        wait_idle();

        // Table of single writes.
        for (int v = 0; v < 4; v++) begin
            decoy_slots();
            set_slot(vecs[v].idx, vecs[v].a, vecs[v].d);
            req = 4'(1) << vecs[v].idx;
            monitor_frame(4'b0000);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_word, vecs[v].exp_ack);
            req = '0;
            wait_idle();
            check($sformatf("vec%0d_busy_gap", v), 32'(m_busy_hi), 32'(CS_GAP));
            check($sformatf("vec%0d_ack_once", v), 32'(m_ack_extra), 32'd0);
        end

        // Slave loopback: last table frame wrote 0x3C to address 1.
        repeat (4) @(negedge clk);
        check("loop_slave_out", 32'(slave_out), 32'h3C);

        // Requester drops req one cycle after grant.
        decoy_slots();
        set_slot(1, 7'h33, 8'hC3);
        req = 4'b0010;
        monitor_frame(4'b0010);
        check_frame("drop", 16'hB3C3, 4'b0010);
        req = '0;
        wait_idle();
        check("drop_req_low", 32'(req), 32'd0);

        // Reset during data bit 5 (frame bit 13), then full restart.
        decoy_slots();
        set_slot(2, 7'h01, 8'hA5);
        req = 4'b0100;
        rises = 0; n = 0; p = 1'b0;
        while (rises < 14 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (sclk && !p) rises++;
            p = sclk;
        end
        check("rstmid_reach",   32'(rises), 32'd14);
        check("rstmid_sclk_hi", 32'(sclk),  32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_cs",   32'(cs),   32'd1);
        check("rstmid_sclk", 32'(sclk), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ack",  32'(ack),  32'd0);
        bad_ack = 0; bad_sclk = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack != '0) bad_ack++;
            if (sclk) bad_sclk++;
        end
        check("rstmid_no_ack",  32'(bad_ack),  32'd0);
        check("rstmid_no_sclk", 32'(bad_sclk), 32'd0);
        rst = 1'b0;
        monitor_frame(4'b0000);
        check_frame("restart", 16'h81A5, 4'b0100);
        req = '0;
        wait_idle();
        check("restart_idle", 32'(m_timeout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
